// File: rtl/ceu_v2p_req_arb.sv
// Round-robin, packet-locked arbiter that merges the CEU engines' write-request streams into one V2P request port.
// Optional debug counters/bus enabled with `define CEU_V2P_ARB_DBG_EN.

module ceu_v2p_req_arb_lane #(
  parameter int DATA_WIDTH = 256,
  parameter int HEAD_WIDTH = 128
) (
  input  logic                  sel,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [HEAD_WIDTH-1:0] head,
  input  logic                  v2p_ready,
  output logic                  ready,
  output logic                  fwd_vld,
  output logic                  fwd_last,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [HEAD_WIDTH-1:0] fwd_head
);
  // Outputs are zero unless this lane owns the channel and has a beat up,
  // so the top can simply OR all lanes together.
  always_comb begin
    ready    = sel & v2p_ready;
    fwd_vld  = sel & valid;
    fwd_last = fwd_vld & last;
    fwd_data = fwd_vld ? data : '0;
    fwd_head = fwd_vld ? head : '0;
  end
endmodule

module ceu_v2p_req_arb #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 256,
  parameter int HEAD_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*HEAD_WIDTH-1:0] req_head,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          v2p_req_valid,
  output logic                          v2p_req_last,
  output logic [DATA_WIDTH-1:0]         v2p_req_data,
  output logic [HEAD_WIDTH-1:0]         v2p_req_head,
  input  logic                          v2p_req_ready,
  output logic [2:0]                    grant_idx
`ifdef CEU_V2P_ARB_DBG_EN
  ,
  output logic [NUM_REQ*16+2+3-1:0]     dbg_bus
`endif
);
  typedef enum logic [1:0] {IDLE = 2'b01, BUSY = 2'b10} state_t;

  state_t     state;
  logic [2:0] rr_ptr;
  logic [2:0] win_idx;
  logic       win_vld;
  logic [2:0] nxt_ptr;
  logic       accept;

  logic [NUM_REQ-1:0]                 ln_sel;
  logic [NUM_REQ-1:0]                 ln_vld;
  logic [NUM_REQ-1:0]                 ln_last;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] ln_data;
  logic [NUM_REQ-1:0][HEAD_WIDTH-1:0] ln_head;

  // Winner = first valid at or above rr_ptr, else lowest valid below it (wrap).
  always_comb begin
    logic       found_hi;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (3'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          hi_idx   = 3'(i);
        end else begin
          lo_idx = 3'(i);
        end
      end
    end
    win_vld = |req_valid;
    win_idx = found_hi ? hi_idx : lo_idx;
  end

  assign nxt_ptr = (grant_idx == 3'(NUM_REQ-1)) ? 3'd0 : grant_idx + 3'd1;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign ln_sel[g] = (state == BUSY) && (grant_idx == 3'(g));
      ceu_v2p_req_arb_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .HEAD_WIDTH(HEAD_WIDTH)
      ) u_lane (
        .sel      (ln_sel[g]),
        .valid    (req_valid[g]),
        .last     (req_last[g]),
        .data     (req_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .head     (req_head[g*HEAD_WIDTH +: HEAD_WIDTH]),
        .v2p_ready(v2p_req_ready),
        .ready    (req_ready[g]),
        .fwd_vld  (ln_vld[g]),
        .fwd_last (ln_last[g]),
        .fwd_data (ln_data[g]),
        .fwd_head (ln_head[g])
      );
    end
  endgenerate

  always_comb begin
    v2p_req_data = '0;
    v2p_req_head = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v2p_req_data = v2p_req_data | ln_data[i];
      v2p_req_head = v2p_req_head | ln_head[i];
    end
    v2p_req_valid = |ln_vld;
    v2p_req_last  = |ln_last;
  end

  assign accept = v2p_req_valid & v2p_req_ready & v2p_req_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          grant_idx <= win_idx;
          state     <= BUSY;
        end
        BUSY: if (accept) begin
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CEU_V2P_ARB_DBG_EN
  logic [NUM_REQ-1:0][15:0] pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (accept && grant_idx == 3'(i)) pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
    end
  end

  assign dbg_bus = {pkt_cnt, state, grant_idx};
`endif
endmodule

// File: tb/tb_ceu_v2p_req_arb.sv
// Directed bench for ceu_v2p_req_arb: single packet, rotation, backpressure,
// late arrival, reset mid-packet and (when enabled) debug packet counters.

module tb_ceu_v2p_req_arb;
  localparam int NR = 3;
  localparam int DW = 256;
  localparam int HW = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR*HW-1:0]  req_head;
  logic [NR-1:0]     req_ready;
  logic              v2p_req_valid;
  logic              v2p_req_last;
  logic [DW-1:0]     v2p_req_data;
  logic [HW-1:0]     v2p_req_head;
  logic              v2p_req_ready;
  logic [2:0]        grant_idx;
`ifdef CEU_V2P_ARB_DBG_EN
  logic [NR*16+4:0]  dbg_bus;
`endif

  int checks = 0;
  int errors = 0;

  ceu_v2p_req_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .HEAD_WIDTH(HW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_head     (req_head),
    .req_ready    (req_ready),
    .v2p_req_valid(v2p_req_valid),
    .v2p_req_last (v2p_req_last),
    .v2p_req_data (v2p_req_data),
    .v2p_req_head (v2p_req_head),
    .v2p_req_ready(v2p_req_ready),
    .grant_idx    (grant_idx)
`ifdef CEU_V2P_ARB_DBG_EN
    ,
    .dbg_bus      (dbg_bus)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [DW-1:0] d, input logic [HW-1:0] h);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DW +: DW] = d;
    req_head[i*HW +: HW] = h;
  endtask

  // Advance to just after the next rising edge; inputs changed here are
  // stable long before the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    int g;
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; req_head = '0;
    v2p_req_ready = 1'b0;
    #12;
    chk("rst_req_ready", 256'(req_ready), 256'd0);
    chk("rst_v2p_valid", 256'(v2p_req_valid), 256'd0);
    chk("rst_v2p_data", v2p_req_data, 256'd0);
    chk("rst_grant", 256'(grant_idx), 256'd0);
    rst_n = 1'b1;

    // Single requester, 2-beat packet
    cyc();
    set_req(0, 1'b1, 1'b0, 256'hD0, 128'h1);
    v2p_req_ready = 1'b1;
    #1;
    chk("t1_idle_valid", 256'(v2p_req_valid), 256'd0);
    chk("t1_idle_ready", 256'(req_ready), 256'd0);
    cyc();
    chk("t1_b0_valid", 256'(v2p_req_valid), 256'd1);
    chk("t1_b0_data", v2p_req_data, 256'hD0);
    chk("t1_b0_head", 256'(v2p_req_head), 256'h1);
    chk("t1_b0_last", 256'(v2p_req_last), 256'd0);
    chk("t1_b0_ready", 256'(req_ready), 256'b001);
    cyc();
    set_req(0, 1'b1, 1'b1, 256'hD1, 128'h1);
    #1;
    chk("t1_b1_data", v2p_req_data, 256'hD1);
    chk("t1_b1_last", 256'(v2p_req_last), 256'd1);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t1_done_valid", 256'(v2p_req_valid), 256'd0);
    chk("t1_rr_ptr", 256'(dut.rr_ptr), 256'd1);

    // Reset restores rr_ptr=0, then all three requesters rotate 0,1,2,0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 256'(32'hA0 + i), 128'(32'h10 + i));
    #1;
    chk("t2_idle_valid", 256'(v2p_req_valid), 256'd0);
    for (int k = 0; k < 4; k++) begin
      g = k % NR;
      cyc();
      chk($sformatf("t2_grant%0d", k), 256'(grant_idx), 256'(g));
      chk($sformatf("t2_ready%0d", k), 256'(req_ready), 256'(1 << g));
      chk($sformatf("t2_data%0d", k), v2p_req_data, 256'(32'hA0 + g));
      cyc();
      chk($sformatf("t2_bubble%0d", k), 256'(v2p_req_valid), 256'd0);
      chk($sformatf("t2_bubble_rdy%0d", k), 256'(req_ready), 256'd0);
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);

    // Backpressure on req1's 3-beat packet; req0 competes but loses (rr_ptr=1)
    cyc();
    set_req(1, 1'b1, 1'b0, 256'hB0, 128'h2);
    set_req(0, 1'b1, 1'b1, 256'hFF, 128'hFF);
    v2p_req_ready = 1'b0;
    cyc();
    chk("t3_grant", 256'(grant_idx), 256'd1);
    chk("t3_s0_data", v2p_req_data, 256'hB0);
    chk("t3_s0_ready", 256'(req_ready), 256'b000);
    cyc();
    v2p_req_ready = 1'b1;
    #1;
    chk("t3_a0_data", v2p_req_data, 256'hB0);
    chk("t3_a0_ready", 256'(req_ready), 256'b010);
    cyc();
    set_req(1, 1'b1, 1'b0, 256'hB1, 128'h2);
    v2p_req_ready = 1'b0;
    #1;
    chk("t3_s1_data", v2p_req_data, 256'hB1);
    chk("t3_s1_ready", 256'(req_ready), 256'b000);
    cyc();
    v2p_req_ready = 1'b1;
    #1;
    chk("t3_a1_data", v2p_req_data, 256'hB1);
    chk("t3_a1_ready", 256'(req_ready), 256'b010);
    cyc();
    set_req(1, 1'b1, 1'b1, 256'hB2, 128'h2);
    #1;
    chk("t3_a2_data", v2p_req_data, 256'hB2);
    chk("t3_a2_last", 256'(v2p_req_last), 256'd1);
    chk("t3_a2_head", 256'(v2p_req_head), 256'h2);
    cyc();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t3_done_valid", 256'(v2p_req_valid), 256'd0);
    chk("t3_rr_ptr", 256'(dut.rr_ptr), 256'd2);

    // Late arrival: req2 raises valid during req0's packet
    set_req(0, 1'b1, 1'b0, 256'hC0, 128'h3);
    cyc();
    set_req(2, 1'b1, 1'b1, 256'hC2, 128'h4);
    #1;
    chk("t4_b0_grant", 256'(grant_idx), 256'd0);
    chk("t4_b0_ready", 256'(req_ready), 256'b001);
    cyc();
    set_req(0, 1'b1, 1'b1, 256'hC1, 128'h3);
    #1;
    chk("t4_b1_grant", 256'(grant_idx), 256'd0);
    chk("t4_b1_data", v2p_req_data, 256'hC1);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t4_idle_valid", 256'(v2p_req_valid), 256'd0);
    chk("t4_idle_ready", 256'(req_ready), 256'b000);
    cyc();
    chk("t4_r2_grant", 256'(grant_idx), 256'd2);
    chk("t4_r2_data", v2p_req_data, 256'hC2);
    chk("t4_r2_ready", 256'(req_ready), 256'b100);
    cyc();
    set_req(2, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t4_rr_ptr", 256'(dut.rr_ptr), 256'd0);

    // Reset while req1 is on beat 2 of a 4-beat packet
    set_req(1, 1'b1, 1'b0, 256'hE0, 128'h5);
    cyc();
    cyc();
    set_req(1, 1'b1, 1'b0, 256'hE1, 128'h5);
    cyc();
    set_req(1, 1'b1, 1'b0, 256'hE2, 128'h5);
    #1;
    chk("t5_pre_valid", 256'(v2p_req_valid), 256'd1);
    chk("t5_pre_data", v2p_req_data, 256'hE2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 256'(v2p_req_valid), 256'd0);
    chk("t5_rst_ready", 256'(req_ready), 256'd0);
    chk("t5_rst_data", v2p_req_data, 256'd0);
    chk("t5_rst_head", 256'(v2p_req_head), 256'd0);
    chk("t5_rst_last", 256'(v2p_req_last), 256'd0);
    chk("t5_rst_grant", 256'(grant_idx), 256'd0);
    chk("t5_rst_state", 256'(dut.state), 256'b01);
    rst_n = 1'b1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t5_rr_ptr", 256'(dut.rr_ptr), 256'd0);

`ifdef CEU_V2P_ARB_DBG_EN
    // 5 single-beat packets from req1, then 2 from req0
    set_req(1, 1'b1, 1'b1, 256'h51, 128'h6);
    for (int k = 0; k < 5; k++) begin
      cyc();
      cyc();
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b1, 256'h50, 128'h7);
    for (int k = 0; k < 2; k++) begin
      cyc();
      cyc();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    d = 256'(dbg_bus);
    chk("dbg_cnt0", 256'(d[20:5]), 256'd2);
    chk("dbg_cnt1", 256'(d[36:21]), 256'd5);
    chk("dbg_cnt2", 256'(d[52:37]), 256'd0);
    chk("dbg_state", 256'(d[4:3]), 256'b01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
